// File: rtl/pc_bkpt_unit.sv
// PC breakpoint / single-step debug unit: halts the core when a PC breakpoint
// fires after its pass count, or when a step budget runs out.
module pc_bkpt_unit #(
    parameter int PC_W  = 11,
    parameter int IDX_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic [PC_W-1:0]       mv_PC,
    input  logic                  lock_rq,
    input  logic [1:0]            mode,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [PC_W-1:0]       cfg_addr,
    input  logic [CNT_W-1:0]      cfg_pass,
    input  logic                  cfg_en,
    input  logic                  step_ld,
    input  logic [CNT_W-1:0]      step_cnt,
    input  logic                  halt_ack,
    input  logic                  ext_pc_reg_sel,
    output logic                  halt_rq,
    output logic [2**IDX_W-1:0]   hit_vec,
    output logic [PC_W-1:0]       halt_pc,
    output logic [1:0]            dbg_state,
    output logic [PC_W-1:0]       pc_reg_dat
);

    localparam int NBP = 2**IDX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN_BP   = 2'b01,
        RUN_STEP = 2'b10,
        HALTED   = 2'b11
    } state_t;

    state_t             state, state_nxt;
    logic               halt_rq_nxt;
    logic [NBP-1:0]     hit_vec_nxt;
    logic [PC_W-1:0]    halt_pc_nxt;
    logic [CNT_W-1:0]   step_rem, step_rem_nxt;

    logic [PC_W-1:0]    bp_addr [NBP];
    logic [CNT_W-1:0]   bp_pass [NBP];
    logic [CNT_W-1:0]   hit_cnt [NBP];
    logic [NBP-1:0]     bp_en;

    logic [NBP-1:0]     wr_sel;
    logic [NBP-1:0]     qual;
    logic [NBP-1:0]     fire;
    logic               step_active;
    logic               step_done;

    // A config write to an entry overrides its match in the same cycle.
    always_comb begin
        wr_sel = '0;
        qual   = '0;
        fire   = '0;
        for (int i = 0; i < NBP; i++) begin
            wr_sel[i] = cfg_we && (cfg_idx == IDX_W'(i));
            qual[i]   = (state == RUN_BP) && (mode == 2'b01) && !lock_rq &&
                        bp_en[i] && (mv_PC == bp_addr[i]) && !wr_sel[i];
            fire[i]   = qual[i] && (hit_cnt[i] == bp_pass[i]);
        end
    end

    assign step_active = (state == RUN_STEP) && (mode == 2'b10) && !lock_rq &&
                         (step_rem != '0);
    assign step_done   = step_active && !step_ld && (step_rem == CNT_W'(1));

    always_comb begin
        state_nxt    = state;
        halt_rq_nxt  = halt_rq;
        hit_vec_nxt  = hit_vec;
        halt_pc_nxt  = halt_pc;
        step_rem_nxt = step_rem;
        if (mode == 2'b00) begin
            state_nxt    = IDLE;
            halt_rq_nxt  = 1'b0;
            hit_vec_nxt  = '0;
            step_rem_nxt = '0;
        end else if (mode == 2'b11) begin
            if (step_ld) begin
                step_rem_nxt = step_cnt;
            end
        end else begin
            if (step_ld) begin
                step_rem_nxt = step_cnt;
            end else if (step_active) begin
                step_rem_nxt = step_rem - CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    state_nxt = (mode == 2'b01) ? RUN_BP : RUN_STEP;
                end
                RUN_BP: begin
                    if (|fire) begin
                        state_nxt   = HALTED;
                        halt_rq_nxt = 1'b1;
                        halt_pc_nxt = mv_PC;
                        hit_vec_nxt = fire;
                    end else if (mode == 2'b10) begin
                        state_nxt = RUN_STEP;
                    end
                end
                RUN_STEP: begin
                    if (step_done) begin
                        state_nxt   = HALTED;
                        halt_rq_nxt = 1'b1;
                        halt_pc_nxt = mv_PC;
                        hit_vec_nxt = '0;
                    end else if (mode == 2'b01) begin
                        state_nxt = RUN_BP;
                    end
                end
                HALTED: begin
                    if (halt_ack) begin
                        state_nxt   = (mode == 2'b01) ? RUN_BP : RUN_STEP;
                        halt_rq_nxt = 1'b0;
                        hit_vec_nxt = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state    <= IDLE;
            halt_rq  <= 1'b0;
            hit_vec  <= '0;
            halt_pc  <= '0;
            step_rem <= '0;
        end else begin
            state    <= state_nxt;
            halt_rq  <= halt_rq_nxt;
            hit_vec  <= hit_vec_nxt;
            halt_pc  <= halt_pc_nxt;
            step_rem <= step_rem_nxt;
        end
    end

    // Entry table; hit counts restart whenever an entry is rewritten or fires.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            bp_en <= '0;
            for (int i = 0; i < NBP; i++) begin
                bp_addr[i] <= '0;
                bp_pass[i] <= '0;
                hit_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBP; i++) begin
                if (wr_sel[i]) begin
                    bp_addr[i] <= cfg_addr;
                    bp_pass[i] <= cfg_pass;
                    bp_en[i]   <= cfg_en;
                    hit_cnt[i] <= '0;
                end else if (mode == 2'b00) begin
                    hit_cnt[i] <= '0;
                end else if (qual[i]) begin
                    hit_cnt[i] <= fire[i] ? '0 : hit_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign dbg_state  = state;
    assign pc_reg_dat = ext_pc_reg_sel ? (halt_rq ? halt_pc : mv_PC) : '0;

endmodule

// File: tb/tb_pc_bkpt_unit.sv
// Directed self-checking bench for pc_bkpt_unit: breakpoints, pass counts,
// stepping with stalls, config/match collision and asynchronous reset.
module tb_pc_bkpt_unit;

    logic        clk = 1'b0;
    logic        reset_b;
    logic [10:0] mv_PC;
    logic        lock_rq;
    logic [1:0]  mode;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [10:0] cfg_addr;
    logic [7:0]  cfg_pass;
    logic        cfg_en;
    logic        step_ld;
    logic [7:0]  step_cnt;
    logic        halt_ack;
    logic        ext_pc_reg_sel;
    logic        halt_rq;
    logic [3:0]  hit_vec;
    logic [10:0] halt_pc;
    logic [1:0]  dbg_state;
    logic [10:0] pc_reg_dat;

    int checks = 0;
    int errors = 0;

    pc_bkpt_unit dut (
        .clk            (clk),
        .reset_b        (reset_b),
        .mv_PC          (mv_PC),
        .lock_rq        (lock_rq),
        .mode           (mode),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_addr       (cfg_addr),
        .cfg_pass       (cfg_pass),
        .cfg_en         (cfg_en),
        .step_ld        (step_ld),
        .step_cnt       (step_cnt),
        .halt_ack       (halt_ack),
        .ext_pc_reg_sel (ext_pc_reg_sel),
        .halt_rq        (halt_rq),
        .hit_vec        (hit_vec),
        .halt_pc        (halt_pc),
        .dbg_state      (dbg_state),
        .pc_reg_dat     (pc_reg_dat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [10:0] pc, input logic lock, input logic [1:0] md);
        mv_PC   = pc;
        lock_rq = lock;
        mode    = md;
        tick();
    endtask

    task automatic applyConfig(input logic [1:0] idx, input logic [10:0] addr,
                               input logic [7:0] pass, input logic en);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_addr = addr;
        cfg_pass = pass;
        cfg_en   = en;
        tick();
        cfg_we   = 1'b0;
    endtask

    initial begin
        reset_b = 1'b0; mv_PC = '0; lock_rq = 1'b0; mode = 2'b00;
        cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_pass = '0; cfg_en = 1'b0;
        step_ld = 1'b0; step_cnt = '0; halt_ack = 1'b0; ext_pc_reg_sel = 1'b0;
        tick();
        tick();
        checkOutput("rst_halt_rq", 32'(halt_rq), 32'h0);
        checkOutput("rst_hit_vec", 32'(hit_vec), 32'h0);
        checkOutput("rst_halt_pc", 32'(halt_pc), 32'h0);
        checkOutput("rst_state", 32'(dbg_state), 32'h0);
        mv_PC = 11'h123; ext_pc_reg_sel = 1'b1; #1;
        checkOutput("pcreg_live", 32'(pc_reg_dat), 32'h123);
        ext_pc_reg_sel = 1'b0; #1;
        checkOutput("pcreg_unsel", 32'(pc_reg_dat), 32'h0);
        reset_b = 1'b1;

        $display("[TB] single breakpoint, pass 0");
        applyConfig(2'd0, 11'h040, 8'd0, 1'b1);
        applyStimulus(11'h000, 1'b0, 2'b01);
        checkOutput("bp0_state_run", 32'(dbg_state), 32'h1);
        checkOutput("bp0_no_halt_yet", 32'(halt_rq), 32'h0);
        applyStimulus(11'h040, 1'b0, 2'b01);
        checkOutput("bp0_halt_rq", 32'(halt_rq), 32'h1);
        checkOutput("bp0_hit_vec", 32'(hit_vec), 32'h1);
        checkOutput("bp0_halt_pc", 32'(halt_pc), 32'h040);
        checkOutput("bp0_state_halt", 32'(dbg_state), 32'h3);
        applyStimulus(11'h050, 1'b0, 2'b01);
        ext_pc_reg_sel = 1'b1; #1;
        checkOutput("pcreg_halted", 32'(pc_reg_dat), 32'h040);
        ext_pc_reg_sel = 1'b0;
        halt_ack = 1'b1;
        applyStimulus(11'h050, 1'b0, 2'b01);
        halt_ack = 1'b0;
        checkOutput("bp0_ack_rq", 32'(halt_rq), 32'h0);
        checkOutput("bp0_ack_vec", 32'(hit_vec), 32'h0);
        checkOutput("bp0_ack_state", 32'(dbg_state), 32'h1);
        checkOutput("bp0_ack_pc_kept", 32'(halt_pc), 32'h040);

        $display("[TB] pass count 2 on entry 2");
        applyConfig(2'd2, 11'h100, 8'd2, 1'b1);
        applyStimulus(11'h100, 1'b0, 2'b01);
        checkOutput("pass_hit1", 32'(halt_rq), 32'h0);
        applyStimulus(11'h101, 1'b0, 2'b01);
        applyStimulus(11'h100, 1'b0, 2'b01);
        checkOutput("pass_hit2", 32'(halt_rq), 32'h0);
        applyStimulus(11'h100, 1'b0, 2'b01);
        checkOutput("pass_hit3_rq", 32'(halt_rq), 32'h1);
        checkOutput("pass_hit3_vec", 32'(hit_vec), 32'h4);
        checkOutput("pass_hit3_pc", 32'(halt_pc), 32'h100);
        halt_ack = 1'b1;
        applyStimulus(11'h000, 1'b0, 2'b01);
        halt_ack = 1'b0;

        $display("[TB] two entries on the same address");
        applyConfig(2'd1, 11'h7FF, 8'd0, 1'b1);
        applyConfig(2'd3, 11'h7FF, 8'd0, 1'b1);
        applyStimulus(11'h7FF, 1'b0, 2'b01);
        checkOutput("dual_rq", 32'(halt_rq), 32'h1);
        checkOutput("dual_vec", 32'(hit_vec), 32'hA);
        checkOutput("dual_pc", 32'(halt_pc), 32'h7FF);
        applyStimulus(11'h7FF, 1'b0, 2'b01);
        checkOutput("dual_held_vec", 32'(hit_vec), 32'hA);
        halt_ack = 1'b1;
        applyStimulus(11'h000, 1'b0, 2'b01);
        halt_ack = 1'b0;
        checkOutput("dual_ack_rq", 32'(halt_rq), 32'h0);
        checkOutput("dual_ack_state", 32'(dbg_state), 32'h1);

        $display("[TB] stalled PC does not match");
        applyStimulus(11'h040, 1'b1, 2'b01);
        checkOutput("lock_no_match", 32'(halt_rq), 32'h0);

        $display("[TB] step run of 3 with one stalled cycle");
        step_ld = 1'b1; step_cnt = 8'd3;
        applyStimulus(11'h200, 1'b0, 2'b10);
        step_ld = 1'b0;
        checkOutput("step_state", 32'(dbg_state), 32'h2);
        applyStimulus(11'h201, 1'b0, 2'b10);
        applyStimulus(11'h201, 1'b1, 2'b10);
        checkOutput("step_locked", 32'(halt_rq), 32'h0);
        applyStimulus(11'h202, 1'b0, 2'b10);
        checkOutput("step_two_done", 32'(halt_rq), 32'h0);
        applyStimulus(11'h203, 1'b0, 2'b10);
        checkOutput("step_halt_rq", 32'(halt_rq), 32'h1);
        checkOutput("step_halt_pc", 32'(halt_pc), 32'h203);
        checkOutput("step_hit_vec", 32'(hit_vec), 32'h0);
        halt_ack = 1'b1;
        applyStimulus(11'h204, 1'b0, 2'b10);
        halt_ack = 1'b0;
        checkOutput("step_ack_state", 32'(dbg_state), 32'h2);
        applyStimulus(11'h205, 1'b0, 2'b10);
        applyStimulus(11'h206, 1'b0, 2'b10);
        checkOutput("step_zero_idle", 32'(halt_rq), 32'h0);

        $display("[TB] config write colliding with a match");
        applyStimulus(11'h000, 1'b0, 2'b01);
        mv_PC = 11'h040;
        applyConfig(2'd0, 11'h040, 8'd0, 1'b1);
        checkOutput("cfg_wins_no_halt", 32'(halt_rq), 32'h0);
        applyStimulus(11'h040, 1'b0, 2'b01);
        checkOutput("cfg_after_halt", 32'(halt_rq), 32'h1);
        checkOutput("cfg_after_vec", 32'(hit_vec), 32'h1);

        $display("[TB] asynchronous reset while halted");
        reset_b = 1'b0; #2;
        checkOutput("arst_rq", 32'(halt_rq), 32'h0);
        checkOutput("arst_vec", 32'(hit_vec), 32'h0);
        checkOutput("arst_pc", 32'(halt_pc), 32'h0);
        checkOutput("arst_state", 32'(dbg_state), 32'h0);
        tick();
        reset_b = 1'b1;
        applyStimulus(11'h040, 1'b0, 2'b01);
        applyStimulus(11'h040, 1'b0, 2'b01);
        checkOutput("arst_no_rehalt", 32'(halt_rq), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_bkpt_unit.md
PC_BKPT_UNIT -- requirements
Module: pc_bkpt_unit

Interface
REQ-001 Parameter PC_W, default 11, program counter width.
REQ-002 Parameter IDX_W, default 2, breakpoint index width; NBP = 2**IDX_W entries.
REQ-003 Parameter CNT_W, default 8, pass-count and step-count width.
REQ-004 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock, all state updates on rising edge.
REQ-006 reset_b  in  1  asynchronous active-low reset.
REQ-007 mv_PC  in  PC_W  current program counter.
REQ-008 lock_rq  in  1  global stall; PC not valid for matching or stepping while high.
REQ-009 mode  in  2  00 off, 01 breakpoint run, 10 step run, 11 freeze.
REQ-010 cfg_we  in  1  write breakpoint entry cfg_idx.
REQ-011 cfg_idx  in  IDX_W  entry select; cfg_addr  in  PC_W  match address; cfg_pass  in  CNT_W  matches to ignore; cfg_en  in  1  entry enable.
REQ-012 step_ld  in  1  load step counter; step_cnt  in  CNT_W  instructions to run.
REQ-013 halt_ack  in  1  host acknowledge, clears halt.
REQ-014 ext_pc_reg_sel  in  1  external PC read select.
REQ-015 halt_rq  out  1  registered halt request to core.
REQ-016 hit_vec  out  NBP  registered, entries that caused current halt.
REQ-017 halt_pc  out  PC_W  registered PC captured at halt.
REQ-018 dbg_state  out  2  FSM state: 00 IDLE, 01 RUN_BP, 10 RUN_STEP, 11 HALTED.
REQ-019 pc_reg_dat  out  PC_W  combinational: ext_pc_reg_sel ? (halt_rq ? halt_pc : mv_PC) : 0.

Function
REQ-020 Per entry: addr, en, pass (CNT_W), hit_cnt (CNT_W); cfg_we writes addr/en/pass of cfg_idx and clears its hit_cnt next edge.
REQ-021 Qualified match for entry i: state RUN_BP, mode==01, lock_rq==0, en[i]==1, mv_PC==addr[i].
REQ-022 Qualified match with hit_cnt[i]==pass[i] SHALL fire entry i; otherwise hit_cnt[i] increments by 1 (no saturation needed since it never exceeds pass).
REQ-023 Any fire: next edge state->HALTED, halt_rq=1, halt_pc=mv_PC, hit_vec=set of all entries firing that cycle, hit_cnt of fired entries=0.
REQ-024 cfg_we to entry i in the same cycle as its qualified match: write wins, no increment, no fire for i; other entries unaffected.
REQ-025 step_ld in any state loads step_rem=step_cnt; in RUN_STEP same cycle, load wins over decrement.
REQ-026 RUN_STEP, mode==10, lock_rq==0, step_rem!=0: step_rem decrements; transition 1->0 causes next edge HALTED, halt_rq=1, halt_pc=mv_PC, hit_vec=0.
REQ-027 RUN_STEP with step_rem==0: no halt, wait for step_ld.
REQ-028 Transitions, priority high to low: mode==00 -> IDLE from any state, clearing halt_rq, hit_vec, all hit_cnt, step_rem (entry config and halt_pc kept); mode==11 -> hold state and all counters; HALTED + halt_ack -> RUN_BP if mode 01, RUN_STEP if mode 10, clearing halt_rq and hit_vec (halt_pc kept); IDLE/RUN_STEP with mode 01 -> RUN_BP; IDLE/RUN_BP with mode 10 -> RUN_STEP.
REQ-029 No matching, counting or decrement in HALTED; halt_ack outside HALTED ignored.
REQ-030 Halt latency: exactly one clock from qualifying cycle to halt_rq=1; halt_ack to halt_rq=0 one clock.

Reset
REQ-031 reset_b low SHALL asynchronously set state IDLE, halt_rq=0, hit_vec=0, halt_pc=0, step_rem=0, all entries addr=0, en=0, pass=0, hit_cnt=0.
REQ-032 Reset mid-halt or mid-step SHALL discard all pending state; no halt after release until re-armed.

Verification
REQ-033 Entry 0 addr=0x040, pass=0, mode 01, PC reaches 0x040 -> halt_rq=1 next cycle, hit_vec=0001, halt_pc=0x040.
REQ-034 Entry 2 pass=2, PC hits 0x100 three times -> halt only on third hit, hit_vec=0100.
REQ-035 Entries 1 and 3 both addr=0x7FF -> single halt, hit_vec=1010; halt_ack -> halt_rq=0, dbg_state=01.
REQ-036 mode 10, step_cnt=3, lock_rq high one cycle mid-run -> halt after 3 unlocked cycles, hit_vec=0.
REQ-037 cfg_we to entry 0 same cycle as its match -> no halt; reset_b pulse while HALTED -> all outputs 0, dbg_state=00.
